// File: rtl/nvm_pkg.sv
// rtl/nvm_pkg.sv - shared NVM types and GC constants
// Holds the GC victim-selector state enum, the invalid-page count type and
// the default free-block threshold shared by the selector and the GC engine.
package nvm_pkg;

    localparam int NVM_PAGE_W   = 6;
    localparam int GC_THRESHOLD = 16;

    // Invalid-page count of one block: 0..2^NVM_PAGE_W inclusive.
    typedef logic [NVM_PAGE_W:0] inv_cnt_t;

    typedef enum logic [2:0] {
        GC_IDLE,
        GC_SCAN,
        GC_DRAIN,
        GC_REQ,
        GC_WAIT_DONE
    } gc_sel_state_t;

endpackage

// File: rtl/gc_victim_sel.sv
// rtl/gc_victim_sel.sv - greedy garbage-collection victim selector
// Scans an external invalid-count table (one-cycle read latency) when the
// free-block count drops below GC_THRESHOLD and offers the block with the
// most invalid pages to the GC engine.
// Ports:
//   CLK, nRST            clock, synchronous active-low reset
//   free_cnt             current free-block count
//   excl_en, excl_blk    block excluded from selection (open write block)
//   inv_rd_addr/data     invalid-count table read port
//   gc_req, gc_victim    victim offer, held until gc_ack
//   gc_ack, gc_done      GC engine handshake
//   gc_none              one-cycle pulse, scan found no eligible block
//   busy                 selector not idle
module gc_victim_sel
    import nvm_pkg::*;
#(
    parameter int BLOCK_W      = 10,
    parameter int PAGE_W       = 6,
    parameter int GC_THRESHOLD = nvm_pkg::GC_THRESHOLD
) (
    input  logic               CLK,
    input  logic               nRST,
    input  logic [BLOCK_W:0]   free_cnt,
    input  logic               excl_en,
    input  logic [BLOCK_W-1:0] excl_blk,
    output logic [BLOCK_W-1:0] inv_rd_addr,
    input  logic [PAGE_W:0]    inv_rd_data,
    output logic               gc_req,
    output logic [BLOCK_W-1:0] gc_victim,
    input  logic               gc_ack,
    input  logic               gc_done,
    output logic               gc_none,
    output logic               busy
);

    localparam int NUM_BLOCKS = 1 << BLOCK_W;
    localparam int PAGES      = 1 << PAGE_W;

    localparam logic [BLOCK_W:0] THRESH    = (BLOCK_W+1)'(GC_THRESHOLD);
    localparam logic [BLOCK_W:0] LAST_ADDR = (BLOCK_W+1)'(NUM_BLOCKS - 1);
    localparam logic [PAGE_W:0]  FULL_CNT  = (PAGE_W+1)'(PAGES);

    gc_sel_state_t state, state_nxt;

    // One bit wider than the address so the final increment lands on
    // NUM_BLOCKS instead of wrapping back to block 0.
    logic [BLOCK_W:0]   scan_cnt;
    logic               cmp_vld;
    logic [BLOCK_W-1:0] cmp_addr;
    logic [PAGE_W:0]    best_cnt;
    logic [BLOCK_W-1:0] best_blk;

    logic               eligible;
    logic               better;
    logic               hit_full;
    logic [PAGE_W:0]    sel_cnt;
    logic [BLOCK_W-1:0] sel_blk;

    // Once the counter has passed the last block the address parks there.
    assign inv_rd_addr = scan_cnt[BLOCK_W] ? LAST_ADDR[BLOCK_W-1:0]
                                           : scan_cnt[BLOCK_W-1:0];
    assign gc_req      = (state == GC_REQ);
    assign busy        = (state != GC_IDLE);

    // Compare the count returned for last cycle's address. Addresses arrive
    // in ascending order, so a strictly-greater test keeps the lower index
    // on a tie. best_cnt == 0 doubles as "no candidate yet".
    always_comb begin
        eligible = cmp_vld && (inv_rd_data != '0)
                   && !(excl_en && (cmp_addr == excl_blk));
        better   = eligible && (inv_rd_data > best_cnt);
        hit_full = eligible && (inv_rd_data == FULL_CNT);
        sel_cnt  = better ? inv_rd_data : best_cnt;
        sel_blk  = better ? cmp_addr    : best_blk;
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= GC_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            GC_IDLE: begin
                if (free_cnt < THRESH) begin
                    state_nxt = GC_SCAN;
                end
            end
            GC_SCAN: begin
                if (hit_full) begin
                    state_nxt = GC_REQ;
                end else if (scan_cnt == LAST_ADDR) begin
                    state_nxt = GC_DRAIN;
                end
            end
            GC_DRAIN: begin
                state_nxt = (sel_cnt != '0) ? GC_REQ : GC_IDLE;
            end
            GC_REQ: begin
                if (gc_ack) begin
                    state_nxt = GC_WAIT_DONE;
                end
            end
            GC_WAIT_DONE: begin
                if (gc_done) begin
                    state_nxt = GC_IDLE;
                end
            end
            default: state_nxt = GC_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            scan_cnt  <= '0;
            cmp_vld   <= 1'b0;
            cmp_addr  <= '0;
            best_cnt  <= '0;
            best_blk  <= '0;
            gc_victim <= '0;
            gc_none   <= 1'b0;
        end else begin
            cmp_vld  <= (state == GC_SCAN);
            cmp_addr <= inv_rd_addr;
            gc_none  <= (state == GC_DRAIN) && (sel_cnt == '0);

            case (state)
                GC_IDLE: begin
                    scan_cnt <= '0;
                    best_cnt <= '0;
                    best_blk <= '0;
                end
                GC_SCAN: begin
                    // An early stop freezes the address on the last one issued.
                    if (!hit_full) begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                    best_cnt <= sel_cnt;
                    best_blk <= sel_blk;
                end
                default: ;
            endcase

            if ((state != GC_REQ) && (state_nxt == GC_REQ)) begin
                gc_victim <= sel_blk;
            end
        end
    end

endmodule

// File: tb/tb_gc_victim_sel.sv
// tb/tb_gc_victim_sel.sv - self-checking bench for gc_victim_sel
module tb_gc_victim_sel;

    localparam int BW = 4;
    localparam int PW = 6;
    localparam int NB = 16;
    localparam int PG = 64;

    logic          CLK = 1'b0;
    logic          nRST = 1'b0;
    logic [BW:0]   free_cnt = 5'd16;
    logic          excl_en = 1'b0;
    logic [BW-1:0] excl_blk = '0;
    logic [BW-1:0] inv_rd_addr;
    logic [PW:0]   inv_rd_data;
    logic          gc_req;
    logic [BW-1:0] gc_victim;
    logic          gc_ack = 1'b0;
    logic          gc_done = 1'b0;
    logic          gc_none;
    logic          busy;

    logic [PW:0]   mem [NB];

    int n_cmp = 0;
    int n_bad = 0;

    gc_victim_sel #(
        .BLOCK_W      (BW),
        .PAGE_W       (PW),
        .GC_THRESHOLD (16)
    ) dut (
        .CLK         (CLK),
        .nRST        (nRST),
        .free_cnt    (free_cnt),
        .excl_en     (excl_en),
        .excl_blk    (excl_blk),
        .inv_rd_addr (inv_rd_addr),
        .inv_rd_data (inv_rd_data),
        .gc_req      (gc_req),
        .gc_victim   (gc_victim),
        .gc_ack      (gc_ack),
        .gc_done     (gc_done),
        .gc_none     (gc_none),
        .busy        (busy)
    );

    always #5 CLK = ~CLK;

    // External invalid-count table with one-cycle read latency.
    always @(posedge CLK) inv_rd_data <= mem[inv_rd_addr];

    typedef struct {
        int bg;
        int blk_a;
        int cnt_a;
        int blk_b;
        int cnt_b;
        bit xen;
        int xblk;
        bit exp_none;
        int exp_vic;
        int exp_lat;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(negedge CLK);
    endtask

    // Reference: a fully invalid eligible block stops the scan at the first
    // such index; otherwise the eligible maximum wins, lowest index on ties.
    function automatic void ref_pick(input bit xen, input int xblk,
                                     output bit none, output int vic,
                                     output int lat);
        int maxc;
        maxc = 0;
        none = 1'b0;
        vic  = 0;
        lat  = NB + 1;
        for (int k = 0; k < NB; k++) begin
            if (mem[k] == PG && !(xen && xblk == k)) begin
                vic = k;
                lat = k + 2;
                return;
            end
        end
        for (int k = 0; k < NB; k++) begin
            if (!(xen && xblk == k) && int'(mem[k]) > maxc) maxc = int'(mem[k]);
        end
        if (maxc == 0) begin
            none = 1'b1;
            return;
        end
        for (int k = NB - 1; k >= 0; k--) begin
            if (!(xen && xblk == k) && int'(mem[k]) == maxc) vic = k;
        end
    endfunction

    task automatic run_scan(input string name, input bit exp_none,
                            input int exp_vic, input int exp_lat,
                            input bit noise, input int hold,
                            input bit keep_low, input int exp_addr);
        int  t;
        bit  seen;
        logic [BW-1:0] v;
        seen = 1'b0;
        free_cnt = 5'd15;
        for (int i = 0; i < 5 && !seen; i++) begin
            tick();
            seen = busy;
        end
        check({name, " scan_start"}, int'(seen), 1);
        if (!seen) return;
        if (!keep_low) free_cnt = 5'd16;
        t = 0;
        while (!(gc_req || gc_none) && t < 40) begin
            if (noise && t == 3) begin
                gc_ack  = 1'b1;
                gc_done = 1'b1;
            end
            tick();
            gc_ack  = 1'b0;
            gc_done = 1'b0;
            t++;
        end
        check({name, " latency"}, t, exp_lat);
        check({name, " gc_none"}, int'(gc_none), int'(exp_none));
        check({name, " gc_req"}, int'(gc_req), int'(!exp_none));
        if (exp_addr >= 0) check({name, " last_addr"}, int'(inv_rd_addr), exp_addr);
        if (!exp_none && gc_req) begin
            check({name, " victim"}, int'(gc_victim), exp_vic);
            v = gc_victim;
            for (int i = 0; i < hold; i++) begin
                tick();
                check({name, " hold_req"}, int'(gc_req), 1);
                check({name, " hold_victim"}, int'(gc_victim), int'(v));
            end
            gc_ack = 1'b1;
            tick();
            gc_ack = 1'b0;
            check({name, " req_drop"}, int'(gc_req), 0);
            check({name, " wait_busy"}, int'(busy), 1);
            tick();
            check({name, " wait_hold"}, int'(busy), 1);
            check({name, " victim_kept"}, int'(gc_victim), int'(v));
            gc_done = 1'b1;
            tick();
            gc_done = 1'b0;
            check({name, " done_idle"}, int'(busy), 0);
        end else if (gc_none) begin
            tick();
            check({name, " none_pulse"}, int'(gc_none), 0);
            check({name, " after_none_busy"}, int'(busy), int'(keep_low));
        end
    endtask

    initial begin
        int  cnt;
        bit  r_none;
        int  r_vic;
        int  r_lat;

        for (int k = 0; k < NB; k++) mem[k] = '0;

        //                bg blkA cntA blkB cntB xen xblk none vic lat
        vecs[0] = '{0,  5, 10,  5, 10, 0, 0, 0,  5, 17};
        vecs[1] = '{7,  3, 20,  9, 20, 0, 0, 0,  3, 17};
        vecs[2] = '{0,  2, 64,  7, 64, 0, 0, 0,  2,  4};
        vecs[3] = '{0,  0,  0,  0,  0, 0, 0, 1,  0, 17};
        vecs[4] = '{0,  4, 30,  4, 30, 1, 4, 1,  0, 17};
        vecs[5] = '{0,  4, 64, 10, 12, 1, 4, 0, 10, 17};
        vecs[6] = '{0, 15, 64, 15, 64, 0, 0, 0, 15, 17};
        vecs[7] = '{0,  0, 64,  0, 64, 0, 0, 0,  0,  2};
        vecs[8] = '{1, 11,  1, 11,  1, 0, 0, 0,  0, 17};

        // Reset state
        nRST = 1'b0;
        tick(); tick(); tick();
        check("rst gc_req", int'(gc_req), 0);
        check("rst gc_none", int'(gc_none), 0);
        check("rst busy", int'(busy), 0);
        check("rst inv_rd_addr", int'(inv_rd_addr), 0);
        check("rst gc_victim", int'(gc_victim), 0);
        nRST = 1'b1;

        // free_cnt equal to threshold must not trigger
        mem[5] = 7'd10;
        free_cnt = 5'd16;
        for (int i = 0; i < 5; i++) tick();
        check("no_trigger_at_16", int'(busy), 0);

        // gc_done while idle is ignored
        gc_done = 1'b1;
        tick();
        gc_done = 1'b0;
        tick();
        check("done_in_idle", int'(busy), 0);

        // Directed table
        for (int v = 0; v < 9; v++) begin
            for (int k = 0; k < NB; k++) mem[k] = 7'(vecs[v].bg);
            mem[vecs[v].blk_a] = 7'(vecs[v].cnt_a);
            mem[vecs[v].blk_b] = 7'(vecs[v].cnt_b);
            excl_en  = vecs[v].xen;
            excl_blk = 4'(vecs[v].xblk);
            run_scan($sformatf("vec%0d", v), vecs[v].exp_none, vecs[v].exp_vic,
                     vecs[v].exp_lat, v == 0, (v == 1) ? 5 : 0, v == 3,
                     (v == 2) ? 3 : -1);
            if (v == 3) begin
                // Rescan started with free_cnt still low; let it finish.
                free_cnt = 5'd16;
                cnt = 0;
                while (busy && cnt < 30) begin
                    tick();
                    cnt++;
                end
                check("rescan_returns_idle", int'(busy), 0);
            end
        end

        // Reset in the middle of a scan discards it
        for (int k = 0; k < NB; k++) mem[k] = '0;
        mem[12] = 7'd30;
        excl_en = 1'b0;
        free_cnt = 5'd15;
        cnt = 0;
        while (!(busy && inv_rd_addr == 4'd8) && cnt < 20) begin
            tick();
            cnt++;
        end
        check("reach_addr8", int'(inv_rd_addr), 8);
        nRST = 1'b0;
        tick();
        check("midrst busy", int'(busy), 0);
        check("midrst gc_req", int'(gc_req), 0);
        check("midrst inv_rd_addr", int'(inv_rd_addr), 0);
        check("midrst gc_victim", int'(gc_victim), 0);
        nRST = 1'b1;
        free_cnt = 5'd16;
        cnt = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (gc_req) cnt++;
        end
        check("midrst no_req", cnt, 0);

        // Randomized against the reference model
        for (int it = 0; it < 25; it++) begin
            for (int k = 0; k < NB; k++) begin
                if ($urandom_range(0, 3) == 0) mem[k] = '0;
                else if ($urandom_range(0, 19) == 0) mem[k] = 7'(PG);
                else mem[k] = 7'($urandom_range(1, 63));
            end
            if (it % 5 == 0) for (int k = 0; k < NB; k++) mem[k] = 7'($urandom_range(0, 1));
            excl_en  = 1'($urandom_range(0, 1));
            excl_blk = 4'($urandom_range(0, NB - 1));
            ref_pick(excl_en, int'(excl_blk), r_none, r_vic, r_lat);
            run_scan($sformatf("rnd%0d", it), r_none, r_vic, r_lat, 1'b0,
                     int'($urandom_range(0, 2)), 1'b0, -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/gc_victim_sel.md
GC_VICTIM_SEL -- requirements
Module: gc_victim_sel

Interface
REQ-001 SHALL have parameter BLOCK_W, default 10: block-index width; NUM_BLOCKS = 2^BLOCK_W.
REQ-002 SHALL have parameter PAGE_W, default 6: page-index width; PAGES = 2^PAGE_W pages per block.
REQ-003 SHALL have parameter GC_THRESHOLD, default 16: free-block level below which GC is triggered.
REQ-004 SHALL have port CLK  in  1  single system clock; all logic on rising edge.
REQ-005 SHALL have port nRST  in  1  reset, synchronous, active-low.
REQ-006 SHALL have port free_cnt  in  BLOCK_W+1  current free-block count, 0..NUM_BLOCKS.
REQ-007 SHALL have port excl_en  in  1  exclude excl_blk from selection.
REQ-008 SHALL have port excl_blk  in  BLOCK_W  block currently open for writes.
REQ-009 SHALL have port inv_rd_addr  out  BLOCK_W  invalid-count table read address.
REQ-010 SHALL have port inv_rd_data  in  PAGE_W+1  invalid-page count of the block addressed the previous cycle, 0..PAGES.
REQ-011 SHALL have port gc_req  out  1  victim available for the GC engine.
REQ-012 SHALL have port gc_victim  out  BLOCK_W  selected victim block.
REQ-013 SHALL have port gc_ack  in  1  GC engine accepts the victim, leaving IDLE.
REQ-014 SHALL have port gc_done  in  1  one-cycle pulse; GC engine reached FINISH.
REQ-015 SHALL have port gc_none  out  1  one-cycle pulse; scan found no eligible victim.
REQ-016 SHALL have port busy  out  1  high in any state other than IDLE.

Function
REQ-017 SHALL implement states IDLE, SCAN, DRAIN, REQ, WAIT_DONE.
REQ-018 IDLE -> SCAN SHALL occur when free_cnt < GC_THRESHOLD; free_cnt == GC_THRESHOLD SHALL NOT trigger.
REQ-019 SCAN SHALL drive inv_rd_addr = 0, 1, ..., NUM_BLOCKS-1, one address per cycle, using a BLOCK_W+1-bit counter so the counter cannot wrap to 0.
REQ-020 Each returned count SHALL be compared one cycle after its address, against the registered address.
REQ-021 A candidate SHALL be eligible only if its count > 0 and it is not (excl_en && address == excl_blk), with excl sampled at the compare cycle.
REQ-022 The best candidate SHALL be the one with the strictly greatest count; on a tie, the lower block index SHALL win.
REQ-023 An eligible count == PAGES (fully invalid block) SHALL end the scan immediately and go to REQ with that block.
REQ-024 After the last address is issued, the FSM SHALL enter DRAIN for one compare cycle.
REQ-025 DRAIN -> REQ SHALL occur if a candidate exists; otherwise DRAIN -> IDLE with gc_none pulsed for exactly 1 cycle.
REQ-026 Full-scan latency SHALL be NUM_BLOCKS+1 cycles from SCAN entry to REQ entry.
REQ-027 In REQ, gc_req SHALL be 1 and gc_victim SHALL be held stable until gc_ack is sampled high; then the FSM SHALL move to WAIT_DONE with gc_req = 0 the next cycle.
REQ-028 WAIT_DONE SHALL return to IDLE on gc_done; the threshold SHALL be re-evaluated in IDLE on the following cycle.
REQ-029 gc_ack outside REQ and gc_done outside WAIT_DONE SHALL be ignored.
REQ-030 free_cnt changes during SCAN, DRAIN, REQ or WAIT_DONE SHALL NOT abort the sequence.
REQ-031 gc_victim SHALL hold its last value outside REQ.

Reset
REQ-032 While nRST = 0 at a clock edge, the block SHALL enter IDLE with gc_req = 0, gc_none = 0, busy = 0, inv_rd_addr = 0, gc_victim = 0, and best-count and scan registers cleared.
REQ-033 Reset asserted mid-scan or mid-handshake SHALL discard the in-progress selection without issuing gc_req.

Structure
REQ-034 nvm_pkg SHALL hold gc_sel_state_t (the 5-state enum), the inv_cnt_t typedef (PAGE_W+1 bits), and GC_THRESHOLD = 16, reused by the GC engine.
REQ-035 gc_victim_sel SHALL be a single module with no sub-module; the invalid-count table SHALL be external.

Verification (NUM_BLOCKS = 16, PAGES = 64, GC_THRESHOLD = 16 in the bench)
REQ-036 free_cnt = 16, then 15; counts all 0 except blk 5 = 10 -> no trigger at 16; at 15, gc_req with gc_victim = 5 exactly 17 cycles after SCAN entry.
REQ-037 blk 3 = 20 and blk 9 = 20, all others lower -> gc_victim = 3 (tie goes to the lower index).
REQ-038 blk 2 = 64, blk 7 = 64 -> scan stops after address 2's compare; gc_victim = 2; no further addresses issued.
REQ-039 All counts 0, or only excl_blk = 4 nonzero with excl_en = 1 -> gc_none pulses 1 cycle; state returns to IDLE and rescans the next cycle while free_cnt < 16.
REQ-040 Hold gc_ack low 5 cycles in REQ -> gc_req and gc_victim stable throughout; gc_ack then gc_done -> IDLE; a gc_done pulse sent while in IDLE has no effect.
REQ-041 nRST = 0 at scan address 8 -> next cycle IDLE, busy = 0; no gc_req is produced from the aborted scan.
